keypad_scan_ctrl: RTL and testbench

//  Sequences 4x4 keypad scanning: rotates one-hot column drive, freezes on press, debounces decoded key,

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_debounce_counter.sv | 29 ++
 rtl/keypad_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  localparam logic [3:0] COL_0 = 4'b1000;
  localparam logic [3:0] COL_1 = 4'b0100;
  localparam logic [3:0] COL_2 = 4'b0010;
  localparam logic [3:0] COL_3 = 4'b0001;

  localparam logic [2:0] SIGN_NONE  = 3'b000;
  localparam logic [2:0] SIGN_SUB   = 3'b100;
  localparam logic [2:0] SIGN_ADD   = 3'b010;
  localparam logic [2:0] SIGN_OP_A  = 3'b001;
  localparam logic [2:0] SIGN_OP_BC = 3'b011;
  localparam logic [2:0] SIGN_EQ    = 3'b111;

  // Any non-one-hot column value recovers to the first column.
  function automatic logic [3:0] next_col(input logic [3:0] col);
    case (col)
      COL_0:   return COL_1;
      COL_1:   return COL_2;
      COL_2:   return COL_3;
      COL_3:   return COL_0;
      default: return COL_0;
    endcase
  endfunction

  function automatic logic col_legal(input logic [3:0] col);
    return (col == COL_0) || (col == COL_1) || (col == COL_2) || (col == COL_3);
  endfunction

endpackage

// File: rtl/keypad_debounce_counter.sv
// Saturating sample counter shared by press and release debouncing.
module keypad_debounce_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic done
);

  logic [W-1:0] cnt;

  // clear together with inc loads 1: the current sample is the first one counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (int'(cnt) < MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // done means the sample taken this cycle completes the required run.
  assign done = (int'(cnt) >= MAX - 1);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner with press/release debounce and one-event-per-press handshake.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  input  logic [2:0] is_sign_key,
  input  logic       key_ready,
  output logic [3:0] col_shift_reg,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [2:0] key_sign,
  output logic       busy
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [3:0]       cap_value;
  logic [2:0]       cap_sign;
  logic             match;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_done;

  assign match = key_pressed && ({key_value, is_sign_key} == {cap_value, cap_sign});

  always_comb begin
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      SCAN: begin
        cnt_clear = key_pressed;
        cnt_inc   = key_pressed;
      end
      DEBOUNCE: cnt_inc = match;
      EMIT:     cnt_clear = key_valid && key_ready;
      RELEASE: begin
        cnt_clear = key_pressed;
        cnt_inc   = !key_pressed;
      end
      default: ;
    endcase
  end

  keypad_debounce_counter #(
    .MAX(DEBOUNCE_CYCLES)
  ) u_cnt (
    .clk  (slow_clk),
    .rst  (rst),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .done (cnt_done)
  );

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state         <= SCAN;
      col_shift_reg <= COL_0;
      div           <= '0;
      key_valid     <= 1'b0;
      key_code      <= '0;
      key_sign      <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (key_pressed) begin
            // Column stays frozen so the decoder keeps reading the same key.
            cap_value <= key_value;
            cap_sign  <= is_sign_key;
            busy      <= 1'b1;
            if (DEBOUNCE_CYCLES == 1) begin
              state     <= EMIT;
              key_valid <= 1'b1;
              key_code  <= key_value;
              key_sign  <= is_sign_key;
            end else begin
              state <= DEBOUNCE;
            end
          end else if (int'(div) >= SCAN_DIV - 1) begin
            col_shift_reg <= next_col(col_shift_reg);
            div           <= '0;
          end else begin
            div <= div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (match) begin
            if (cnt_done) begin
              state     <= EMIT;
              key_valid <= 1'b1;
              key_code  <= cap_value;
              key_sign  <= cap_sign;
            end
          end else begin
            state         <= SCAN;
            busy          <= 1'b0;
            col_shift_reg <= next_col(col_shift_reg);
            div           <= '0;
          end
        end
        EMIT: begin
          if (key_ready) begin
            state     <= RELEASE;
            key_valid <= 1'b0;
          end
        end
        RELEASE: begin
          if (!key_pressed && cnt_done) begin
            state         <= SCAN;
            busy          <= 1'b0;
            col_shift_reg <= next_col(col_shift_reg);
            div           <= '0;
          end
        end
        default: begin
          state <= SCAN;
          busy  <= 1'b0;
        end
      endcase
      if (!col_legal(col_shift_reg)) col_shift_reg <= COL_0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=2, DEBOUNCE_CYCLES=4.
module tb_keypad_scan_ctrl;

  logic       slow_clk = 1'b0;
  logic       rst;
  logic       key_pressed;
  logic [3:0] key_value;
  logic [2:0] is_sign_key;
  logic       key_ready;
  logic [3:0] col_shift_reg;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] key_sign;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int events   = 0;

  keypad_scan_ctrl #(
    .SCAN_DIV(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .key_pressed  (key_pressed),
    .key_value    (key_value),
    .is_sign_key  (is_sign_key),
    .key_ready    (key_ready),
    .col_shift_reg(col_shift_reg),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_sign     (key_sign),
    .busy         (busy)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [3:0] col);
    chk({tag, "_col"}, 8'(col_shift_reg), 8'(col));
    chk({tag, "_valid"}, 8'(key_valid), 8'h0);
    chk({tag, "_busy"}, 8'(busy), 8'h0);
  endtask

  task automatic press(input logic [3:0] v, input logic [2:0] s);
    key_pressed = 1'b1;
    key_value   = v;
    is_sign_key = s;
  endtask

  task automatic unpress();
    key_pressed = 1'b0;
    key_value   = 4'h0;
    is_sign_key = 3'b000;
  endtask

  initial begin
    logic [3:0] exp_cols [9];
    exp_cols = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010,
                 4'b0010, 4'b0001, 4'b0001, 4'b1000};
    rst = 1'b1;
    key_ready = 1'b0;
    unpress();
    step();
    step();
    chk("rst_col", 8'(col_shift_reg), 8'h8);
    chk("rst_valid", 8'(key_valid), 8'h0);
    chk("rst_code", 8'(key_code), 8'h0);
    chk("rst_sign", 8'(key_sign), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    rst = 1'b0;

    // 1: free-running rotation, two cycles per column
    chk_idle("scan0", exp_cols[0]);
    for (int i = 1; i < 9; i++) begin
      step();
      chk_idle($sformatf("scan%0d", i), exp_cols[i]);
    end

    // 2: '5' pressed on column 0010 with consumer ready
    for (int i = 0; i < 4; i++) step();
    chk("t2_col_start", 8'(col_shift_reg), 8'h2);
    press(4'b0101, 3'b000);
    key_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("t2_deb_valid%0d", i), 8'(key_valid), 8'h0);
      chk($sformatf("t2_deb_busy%0d", i), 8'(busy), 8'h1);
      chk($sformatf("t2_deb_col%0d", i), 8'(col_shift_reg), 8'h2);
    end
    step();
    chk("t2_valid", 8'(key_valid), 8'h1);
    chk("t2_code", 8'(key_code), 8'h5);
    chk("t2_sign", 8'(key_sign), 8'h0);
    for (int i = 5; i <= 12; i++) begin
      step();
      chk($sformatf("t2_held_valid%0d", i), 8'(key_valid), 8'h0);
      chk($sformatf("t2_held_col%0d", i), 8'(col_shift_reg), 8'h2);
      chk($sformatf("t2_held_busy%0d", i), 8'(busy), 8'h1);
    end
    unpress();
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("t2_rel_busy%0d", i), 8'(busy), 8'h1);
    end
    step();
    chk_idle("t2_done", 4'b0001);
    chk("t2_code_hold", 8'(key_code), 8'h5);

    // 3a: bounce -- two press samples then low
    press(4'b0101, 3'b000);
    step();
    chk("t3_busy", 8'(busy), 8'h1);
    step();
    chk("t3_valid", 8'(key_valid), 8'h0);
    unpress();
    step();
    chk_idle("t3_abort", 4'b1000);
    // 3b: '0' turns into '*' mid-debounce
    press(4'b0000, 3'b000);
    step();
    chk("t3b_busy", 8'(busy), 8'h1);
    chk("t3b_col", 8'(col_shift_reg), 8'h8);
    press(4'b0000, 3'b100);
    step();
    chk_idle("t3b_abort", 4'b0100);
    unpress();

    // 4: 'D' with consumer stalled, key released while event pending
    key_ready = 1'b0;
    press(4'b1111, 3'b111);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i < 4) begin
        chk($sformatf("t4_pre_valid%0d", i), 8'(key_valid), 8'h0);
      end else begin
        chk($sformatf("t4_valid%0d", i), 8'(key_valid), 8'h1);
        chk($sformatf("t4_code%0d", i), 8'(key_code), 8'hf);
        chk($sformatf("t4_sign%0d", i), 8'(key_sign), 8'h7);
      end
      if (i == 8) unpress();
    end
    key_ready = 1'b1;
    step();
    chk("t4_accept_valid", 8'(key_valid), 8'h0);
    chk("t4_accept_busy", 8'(busy), 8'h1);
    chk("t4_accept_code", 8'(key_code), 8'hf);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("t4_rel_busy%0d", i), 8'(busy), 8'h1);
    end
    step();
    chk_idle("t4_done", 4'b0010);

    // 5: release glitch restarts the release count
    press(4'b0011, 3'b010);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (key_valid) events++;
    end
    unpress();
    for (int i = 1; i <= 3; i++) begin
      step();
      if (key_valid) events++;
      chk($sformatf("t5_low_busy%0d", i), 8'(busy), 8'h1);
    end
    press(4'b0011, 3'b010);
    step();
    if (key_valid) events++;
    chk("t5_glitch_busy", 8'(busy), 8'h1);
    unpress();
    for (int i = 1; i <= 3; i++) begin
      step();
      if (key_valid) events++;
      chk($sformatf("t5_low2_busy%0d", i), 8'(busy), 8'h1);
    end
    step();
    if (key_valid) events++;
    chk_idle("t5_done", 4'b0001);
    chk("t5_events", 8'(events), 8'h1);
    chk("t5_code", 8'(key_code), 8'h3);
    chk("t5_sign", 8'(key_sign), 8'h2);

    // 6a: reset during DEBOUNCE
    press(4'b0111, 3'b000);
    step();
    chk("t6a_busy", 8'(busy), 8'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    unpress();
    chk_idle("t6a", 4'b1000);
    chk("t6a_code", 8'(key_code), 8'h0);
    chk("t6a_sign", 8'(key_sign), 8'h0);

    // 6b: reset while an event is pending
    key_ready = 1'b0;
    press(4'b1010, 3'b001);
    for (int i = 0; i < 4; i++) step();
    chk("t6b_valid", 8'(key_valid), 8'h1);
    chk("t6b_code", 8'(key_code), 8'ha);
    rst = 1'b1;
    step();
    rst = 1'b0;
    unpress();
    chk_idle("t6b", 4'b1000);
    chk("t6b_code_rst", 8'(key_code), 8'h0);
    chk("t6b_sign_rst", 8'(key_sign), 8'h0);
    step();
    chk_idle("t6b_after", 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
